piso_serializer_tx: RTL and testbench
=====================================

Name: piso_serializer_tx

Overview:
Parallel-in, serial-out transmit stage that feeds a serial-in/parallel-out shift register directly downstream.
- Accepts one WIDTH-bit word through a valid/ready handshake.
- Drives ShiftIn with one data bit at a time, MSB first.
- Pulses ShiftEn once per bit period, so a 4-bit downstream SIPO holds the original word after WIDTH shifts.
- Paces the bit rate with an internal divider; reports Busy and a Done pulse.

Parameters:
WIDTH, 4, data word width in bits (>=2)
CLK_DIV, 1, Clk cycles per bit period (>=1); 1 = one bit per cycle

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  reset, asynchronous, active-high
LoadValid  input  1  upstream word available
LoadData  input  WIDTH  word to serialize
LoadReady  output  1  block can accept a word (high only in IDLE)
ShiftIn  output  1  current serial bit to downstream
ShiftEn  output  1  one-cycle strobe; downstream samples ShiftIn when high
Busy  output  1  frame in progress (state != IDLE)
Done  output  1  one-cycle pulse coinciding with final ShiftEn of a frame

Behaviour:
- Clock and reset:
  - Single clock domain: Clk.
  - Reset is asynchronous, active-high. While asserted, all state clears immediately.
- Reset values: state=IDLE, LoadReady=1 (combinational from state), ShiftIn=0, ShiftEn=0, Busy=0, Done=0, shift register=0, counters=0.
- States:
  - IDLE: LoadReady=1, ShiftIn=0, ShiftEn=0. On LoadValid&&LoadReady, capture LoadData into shift register, clear div and bit counters, go to SHIFT.
  - SHIFT: ShiftIn=shift register MSB, held stable for a whole bit period.
    - div counter counts 0..CLK_DIV-1. ShiftEn=1 only in the cycle where div counter==CLK_DIV-1.
    - On that cycle: shift register shifts left with 0 fill, bit counter increments, div counter wraps to 0.
    - On the ShiftEn of bit WIDTH-1: Done=1; next state IDLE (or PARITY if PARITY_EN is defined).
- Latency: handshake accepted at edge 0.
  - First ShiftEn is in cycle CLK_DIV after acceptance.
  - Final ShiftEn/Done is in cycle WIDTH*CLK_DIV.
  - LoadReady=1 in the following cycle.
  - Back-to-back frames have a minimum 1-cycle IDLE gap.
- LoadValid in SHIFT is ignored (LoadReady=0); LoadData is not sampled.
- CLK_DIV=1: ShiftEn is high on every SHIFT cycle; the div counter is constant 0.
- Counter widths: div counter $clog2(CLK_DIV) bits, minimum 1; bit counter $clog2(WIDTH+1) bits. No wrap is reachable beyond the defined terminal counts.
- Reset mid-frame: the frame is abandoned. No Done is emitted, outputs take reset values, and the next accepted word starts a fresh frame.
- Done and ShiftEn are never high outside SHIFT/PARITY.

Optional Feature:
Macro SERIAL_PARITY_EN.
- Defined: after the WIDTH data bits, enter PARITY state for one bit period.
  - ShiftIn = even parity (XOR) of the captured word.
  - ShiftEn strobes at the end of the period, as in SHIFT.
  - Done moves to the parity ShiftEn. Frame length becomes (WIDTH+1)*CLK_DIV cycles.
- Undefined: PARITY state and parity register are absent; frame is WIDTH bits as above.

Decomposition:
- Shared package serial_pkg holds:
  - state enum typedef (IDLE, SHIFT, PARITY);
  - default constants DEF_WIDTH=4 and DEF_CLK_DIV=1;
  - function for counter width: max(1, $clog2(n)).
- One natural sub-module: piso_tick_gen.
  - Parameter CLK_DIV; inputs Clk, Reset, Run; output Tick.
  - Tick is high in the last cycle of each period while Run is high; the counter clears when Run is low.
  - The top-level FSM drives Run=Busy and uses Tick as ShiftEn.

Test Plan:
- WIDTH=4, CLK_DIV=1, load 4'b1011 -> ShiftIn sequence 1,0,1,1 on 4 consecutive ShiftEn cycles; Done with 4th; downstream SIPO ParallelOut=4'b1011; LoadReady high next cycle.
- WIDTH=4, CLK_DIV=3, load 4'b0110 -> ShiftEn at cycles 3,6,9,12 after acceptance; ShiftIn stable across each 3-cycle period; Done at cycle 12.
- LoadValid held high, words 4'hA then 4'h5 -> second word accepted exactly one IDLE cycle after first Done. LoadValid pulses during SHIFT are ignored; serial output unaffected.
- Reset asserted asynchronously mid-frame after 2 bits of 4'hF -> outputs at reset values immediately, no Done. Next load 4'h3 serializes 0,0,1,1 correctly.
- SERIAL_PARITY_EN, WIDTH=4, CLK_DIV=1, load 4'b0111 -> ShiftIn 0,1,1,1 then parity 1 on 5th ShiftEn; Done on 5th only.
- Idle soak, LoadValid=0 for 100 cycles -> ShiftEn=0, Done=0, Busy=0, ShiftIn=0 throughout.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types, defaults and sizing helper for the PISO serializer slice.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } serialState_e;

  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_CLK_DIV = 1;

  // max(1, $clog2(n)) so a counter of a single state still has one bit.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_tx_if.sv
// Load handshake and serial output bundle between upstream, serializer and downstream SIPO.
interface piso_serializer_tx_if
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             LoadValid;
  logic [WIDTH-1:0] LoadData;
  logic             LoadReady;
  logic             ShiftIn;
  logic             ShiftEn;
  logic             Busy;
  logic             Done;

  modport master (
    output LoadValid,
    output LoadData,
    input  LoadReady,
    input  ShiftIn,
    input  ShiftEn,
    input  Busy,
    input  Done
  );

  modport slave (
    input  LoadValid,
    input  LoadData,
    output LoadReady,
    output ShiftIn,
    output ShiftEn,
    output Busy,
    output Done
  );

endinterface

// File: rtl/piso_tick_gen.sv
// Bit-period divider: Tick is high in the last Clk cycle of each CLK_DIV-cycle period while Run.
module piso_tick_gen
  import serial_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  output logic Tick
);

  localparam int unsigned DivW = cntWidth(CLK_DIV);
  localparam logic [DivW-1:0] LastCnt = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] divCnt;

  // Held at zero while idle so each frame starts on a fresh period.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      divCnt <= '0;
    end else if (!Run || (divCnt == LastCnt)) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

  assign Tick = Run && (divCnt == LastCnt);

endmodule

// File: rtl/piso_serializer_tx.sv
// MSB-first parallel-to-serial transmitter feeding a downstream SIPO via ShiftIn/ShiftEn.
// Optional macro SERIAL_PARITY_EN appends one even-parity bit period after the data bits.
module piso_serializer_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic                 Clk,
  input  logic                 Reset,
  piso_serializer_tx_if.slave  bus
);

  localparam int unsigned BitW = cntWidth(WIDTH + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

  serialState_e     state;
  logic [WIDTH-1:0] shiftReg;
  logic [BitW-1:0]  bitCnt;
  logic             busy;
  logic             tick;
  logic             lastData;
`ifdef SERIAL_PARITY_EN
  logic             parityBit;
`endif

  assign busy     = (state != IDLE);
  assign lastData = (state == SHIFT) && (bitCnt == LastBit);

  piso_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .Clk   (Clk),
    .Reset (Reset),
    .Run   (busy),
    .Tick  (tick)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      bitCnt   <= '0;
`ifdef SERIAL_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.LoadValid) begin
            shiftReg <= bus.LoadData;
            bitCnt   <= '0;
            state    <= SHIFT;
`ifdef SERIAL_PARITY_EN
            parityBit <= ^bus.LoadData;
`endif
          end
        end
        SHIFT: begin
          if (tick) begin
            shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
            bitCnt   <= bitCnt + 1'b1;
            if (lastData) begin
`ifdef SERIAL_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
`endif
            end
          end
        end
`ifdef SERIAL_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.LoadReady = (state == IDLE);
  assign bus.Busy      = busy;
  assign bus.ShiftEn   = tick;

`ifdef SERIAL_PARITY_EN
  assign bus.ShiftIn = (state == SHIFT)  ? shiftReg[WIDTH-1] :
                       (state == PARITY) ? parityBit : 1'b0;
  assign bus.Done    = tick && (state == PARITY);
`else
  assign bus.ShiftIn = (state == SHIFT) && shiftReg[WIDTH-1];
  assign bus.Done    = tick && lastData;
`endif

endmodule

// File: tb/tb_piso_serializer_tx.sv
// Randomized bench for piso_serializer_tx: two instances (CLK_DIV=1 and 3) against a frame-timing model.
module tb_piso_serializer_tx;

  localparam int unsigned W = 4;
`ifdef SERIAL_PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int total = 0;
  int bad = 0;

  piso_serializer_tx_if #(.WIDTH(W)) bus1 ();
  piso_serializer_tx_if #(.WIDTH(W)) bus3 ();

  piso_serializer_tx #(.WIDTH(W), .CLK_DIV(1)) dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus1)
  );

  piso_serializer_tx #(.WIDTH(W), .CLK_DIV(3)) dut3 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus3)
  );

  always #5 Clk = ~Clk;

  // Observation vector: {LoadReady, Busy, ShiftEn, Done, ShiftIn}
  function automatic logic [4:0] obs(input int sel);
    if (sel != 0) return {bus3.LoadReady, bus3.Busy, bus3.ShiftEn, bus3.Done, bus3.ShiftIn};
    return {bus1.LoadReady, bus1.Busy, bus1.ShiftEn, bus1.Done, bus1.ShiftIn};
  endfunction

  task automatic drive(input int sel, input logic v, input logic [W-1:0] d);
    if (sel != 0) begin
      bus3.LoadValid = v;
      bus3.LoadData  = d;
    end else begin
      bus1.LoadValid = v;
      bus1.LoadData  = d;
    end
  endtask

  // j-th transmitted bit of a frame: data MSB first, then even parity if enabled.
  function automatic logic exp_bit(input logic [W-1:0] w, input int j);
    if (j < int'(W)) return w[int'(W) - 1 - j];
    return ^w;
  endfunction

  // Entered and left just after a negedge; the word is accepted at the next posedge.
  task automatic run_frame(input int sel, input logic [W-1:0] word, input bit hold,
                           input bit noise, input string tag);
    int div;
    int len;
    logic [4:0] got;
    logic [4:0] want;
    logic [W:0] sipo;
    logic [W:0] sexp;
    div = (sel != 0) ? 3 : 1;
    len = NBITS * div;
    got = obs(sel);
    total++;
    if (got !== 5'b10000) begin
      bad++;
      $display("FAIL %s idle_before got=%b want=%b", tag, got, 5'b10000);
    end
    drive(sel, 1'b1, word);
    @(posedge Clk);
    @(negedge Clk);
    sipo = '0;
    sexp = '0;
    for (int j = 0; j < NBITS; j++) sexp = {sexp[W-1:0], exp_bit(word, j)};
    for (int k = 1; k <= len; k++) begin
      want = {1'b0, 1'b1, (k % div) == 0, k == len, exp_bit(word, (k - 1) / div)};
      got = obs(sel);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s cycle=%0d got=%b want=%b", tag, k, got, want);
      end
      if (got[2] === 1'b1) sipo = {sipo[W-1:0], got[0]};
      if (k == len) drive(sel, hold, W'($urandom));
      else if (noise) drive(sel, 1'($urandom_range(0, 1)), W'($urandom));
      else drive(sel, 1'b0, word);
      @(negedge Clk);
    end
    total++;
    if (sipo !== sexp) begin
      bad++;
      $display("FAIL %s sipo got=%b want=%b", tag, sipo, sexp);
    end
    got = obs(sel);
    total++;
    if (got !== 5'b10000) begin
      bad++;
      $display("FAIL %s ready_after got=%b want=%b", tag, got, 5'b10000);
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    @(negedge Clk);
    for (int s = 0; s < 2; s++) begin
      got = obs(s);
      total++;
      if (got !== 5'b10000) begin
        bad++;
        $display("FAIL reset_held dut=%0d got=%b want=%b", s, got, 5'b10000);
      end
    end
    Reset = 1'b0;
    @(negedge Clk);
    for (int s = 0; s < 2; s++) begin
      got = obs(s);
      total++;
      if (got !== 5'b10000) begin
        bad++;
        $display("FAIL reset_released dut=%0d got=%b want=%b", s, got, 5'b10000);
      end
    end
  endtask

  task automatic test_basic();
    run_frame(0, 4'b1011, 1'b0, 1'b0, "basic_1011");
    run_frame(0, 4'b0111, 1'b0, 1'b0, "basic_0111");
  endtask

  task automatic test_clk_div();
    run_frame(1, 4'b0110, 1'b0, 1'b0, "div3_0110");
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      run_frame(s, 4'hA, 1'b1, 1'b1, "b2b_A");
      run_frame(s, 4'h5, 1'b0, 1'b1, "b2b_5");
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] got;
    int nEn;
    nEn = 0;
    drive(1, 1'b1, 4'hF);
    @(posedge Clk);
    @(negedge Clk);
    drive(1, 1'b0, 4'hF);
    for (int k = 1; k <= 7; k++) begin
      got = obs(1);
      if (got[2] === 1'b1) nEn++;
      if (k < 7) @(negedge Clk);
    end
    total++;
    if (nEn != 2) begin
      bad++;
      $display("FAIL midreset_bits got=%0d want=%0d", nEn, 2);
    end
    #1 Reset = 1'b1;
    #1;
    got = obs(1);
    total++;
    if (got !== 5'b10000) begin
      bad++;
      $display("FAIL midreset_async got=%b want=%b", got, 5'b10000);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      got = obs(1);
      total++;
      if (got !== 5'b10000) begin
        bad++;
        $display("FAIL midreset_hold cycle=%0d got=%b want=%b", k, got, 5'b10000);
      end
    end
    Reset = 1'b0;
    @(negedge Clk);
    run_frame(1, 4'h3, 1'b0, 1'b0, "after_reset_3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      run_frame(i % 2, W'($urandom), 1'b0, 1'b1, "random");
    end
  endtask

  task automatic test_idle_soak();
    logic [4:0] got;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    for (int k = 0; k < 100; k++) begin
      @(negedge Clk);
      for (int s = 0; s < 2; s++) begin
        got = obs(s);
        total++;
        if (got !== 5'b10000) begin
          bad++;
          $display("FAIL idle_soak dut=%0d cycle=%0d got=%b want=%b", s, k, got, 5'b10000);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clk_div();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_idle_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
